// File: rtl/store_narrow_unit.sv
// store_narrow_unit: byte/half/word store engine.
// Byte and half stores read the containing word, replace the target lanes
// and write the word back. Word stores write directly. Misaligned or
// illegal requests raise a one-cycle err and make no memory access.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; request fields captured on acceptance
// S_READ  | mem_re held until mem_ready, then the read word is merged
// S_WRITE | mem_we held with merged data until mem_ready
// S_DONE  | one-cycle done pulse
// S_ERROR | one-cycle err pulse, no memory access
module store_narrow_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;

    logic        illegal;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [31:0] merged;

    // Request legality, evaluated on the live inputs at acceptance.
    always_comb begin
        illegal = 1'b0;
        case (size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr[0];
            2'b10:   illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Replace the addressed lanes of the word just read. In big-endian
    // order the lane position is mirrored, so byte offset k sits at lane 3-k
    // and the half at offset 0 occupies the upper 16 bits.
    always_comb begin
        byte_lane = BIG_ENDIAN ? ~addr_q : addr_q;
        half_lane = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
        merged    = mem_rdata;
        case (size_q)
            2'b00:   merged[{byte_lane, 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{half_lane, 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= addr[1:0];
                        wdata_q  <= wdata;
                        size_q   <= size;
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (illegal) begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end else if (size == 2'b10) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                            state     <= S_WRITE;
                        end else begin
                            mem_re <= 1'b1;
                            state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ready) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: a little-endian and a big-endian instance
// share all inputs; each is checked cycle by cycle against a byte-array
// model of the store and a per-cycle phase schedule.
module tb_store_narrow_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] maddr [2];
    logic        mre   [2];
    logic        mwe   [2];
    logic [31:0] mwdata[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic        err_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    store_narrow_unit #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
        .size(size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_addr(maddr[0]), .mem_re(mre[0]), .mem_we(mwe[0]),
        .mem_wdata(mwdata[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    store_narrow_unit #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
        .size(size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_addr(maddr[1]), .mem_re(mre[1]), .mem_we(mwe[1]),
        .mem_wdata(mwdata[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b1;
            2'b01:   return a[0] == 1'b0;
            2'b10:   return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Memory word viewed as four bytes by address offset; apply the store
    // to that view, then pack it back into the bus word for the given order.
    function automatic logic [31:0] model_word(input bit be, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [1:0] sz,
                                               input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          off;
        off = int'(a[1:0]);
        for (int k = 0; k < 4; k++) b[k] = be ? rd[8*(3-k) +: 8] : rd[8*k +: 8];
        if (sz == 2'b10) return wd;
        if (sz == 2'b00) begin
            b[off] = wd[7:0];
        end else if (be) begin
            b[off] = wd[15:8];
            b[off+1] = wd[7:0];
        end else begin
            b[off] = wd[7:0];
            b[off+1] = wd[15:8];
        end
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (be) w[8*(3-k) +: 8] = b[k];
            else    w[8*k +: 8] = b[k];
        end
        return w;
    endfunction

    task automatic check_outputs(input string tag, input int ph, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz,
                                 input logic [31:0] rd);
        for (int d = 0; d < 2; d++) begin
            string t;
            t = $sformatf("%s d%0d ph%0d", tag, d, ph);
            check({t, " busy"}, 32'(busy_o[d]), 32'(ph != 0));
            check({t, " re"},   32'(mre[d]),    32'(ph == 1));
            check({t, " we"},   32'(mwe[d]),    32'(ph == 2));
            check({t, " done"}, 32'(done_o[d]), 32'(ph == 3));
            check({t, " err"},  32'(err_o[d]),  32'(ph == 4));
            if (ph == 1 || ph == 2)
                check({t, " addr"}, maddr[d], {a[31:2], 2'b00});
            if (ph == 2)
                check({t, " wdata"}, mwdata[d], model_word(d == 1, a, wd, sz, rd));
        end
    endtask

    // Phases: 0 idle, 1 read, 2 write, 3 done, 4 error. Each store is
    // observed through its first idle cycle afterwards. With pre set, start
    // was already left high by the previous call.
    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input logic [31:0] rd,
                             input int rw, input int ww, input bit pre, input bit hold);
        int  ws, last, ph;
        bit  narrow;
        narrow = (sz != 2'b10);
        ws = narrow ? rw + 2 : 1;
        last = is_legal(a, sz) ? ws + ww + 2 : 2;
        if (!pre) begin
            start = 1'b1; addr = a; wdata = wd; size = sz;
            mem_ready = 1'($urandom); mem_rdata = $urandom;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (!is_legal(a, sz))      ph = (c == 1) ? 4 : 0;
            else if (narrow && c < ws) ph = 1;
            else if (c < ws + ww + 1)  ph = 2;
            else if (c == ws + ww + 1) ph = 3;
            else                       ph = 0;
            check_outputs($sformatf("%s c%0d", tag, c), ph, a, wd, sz, rd);
            mem_rdata = $urandom;
            if (ph == 1) begin
                mem_ready = (c == rw + 1);
                if (mem_ready) mem_rdata = rd;
            end else if (ph == 2) begin
                mem_ready = (c == ws + ww);
            end else begin
                mem_ready = 1'($urandom);
            end
            if (hold) begin
                start = 1'b1;
            end else begin
                start = (c == last) ? 1'b0 : 1'($urandom);
                addr = $urandom; wdata = $urandom; size = 2'($urandom);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d busy", tag, d),  32'(busy_o[d]), 32'd0);
            check($sformatf("%s d%0d re", tag, d),    32'(mre[d]),    32'd0);
            check($sformatf("%s d%0d we", tag, d),    32'(mwe[d]),    32'd0);
            check($sformatf("%s d%0d done", tag, d),  32'(done_o[d]), 32'd0);
            check($sformatf("%s d%0d err", tag, d),   32'(err_o[d]),  32'd0);
            check($sformatf("%s d%0d addr", tag, d),  maddr[d],       32'd0);
            check($sformatf("%s d%0d wdata", tag, d), mwdata[d],      32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; addr = '0; wdata = '0; size = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_store("byte_le",  32'h103, 32'h0000_00AB, 2'b00, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
        run_store("half_be",  32'h202, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
        run_store("word_w2",  32'h040, 32'hDEAD_BEEF, 2'b10, 32'h1122_3344, 0, 2, 1'b0, 1'b0);
        run_store("half_mis", 32'h101, 32'h0000_1234, 2'b01, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
        run_store("size_11",  32'h100, 32'h0000_1234, 2'b11, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
        run_store("word_mis", 32'h042, 32'h0000_1234, 2'b10, 32'h1122_3344, 0, 0, 1'b0, 1'b0);

        // Reset during a stalled read: outputs clear immediately, no write
        // follows, and the next request runs normally.
        start = 1'b1; addr = 32'h300; wdata = 32'h55; size = 2'b00; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("rst_mid re0", 32'(mre[0]), 32'd1);
            check("rst_mid re1", 32'(mre[1]), 32'd1);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst busy0", 32'(busy_o[0]), 32'd0);
            check("post_rst we1",   32'(mwe[1]),    32'd0);
        end
        run_store("after_rst", 32'h301, 32'h0000_00C3, 2'b00, 32'hA0B1_C2D3, 1, 1, 1'b0, 1'b0);

        // start held high: one store, then the next accepted right after done.
        run_store("hold_a", 32'h402, 32'h0000_7E5A, 2'b01, 32'h0F0F_0F0F, 0, 0, 1'b0, 1'b1);
        run_store("hold_b", 32'h402, 32'h0000_7E5A, 2'b01, 32'h0F0F_0F0F, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [1:0]  rs;
            ra = $urandom;
            rs = 2'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                if (rs == 2'b10) ra[1:0] = 2'b00;
                if (rs == 2'b01) ra[0] = 1'b0;
            end
            run_store($sformatf("rnd%0d", i), ra, $urandom, rs, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
